// File: rtl/kbd_fifo.sv
// kbd_fifo: keyboard receive buffer between the PS/2 receiver and the port
// controller. Each rising edge of ps2_hit captures ps2_data into a
// 2^DEPTH_LOG2-entry FIFO. irq stays high while bytes are pending. The oldest
// byte is presented on data_o and popped by a one-cycle rd strobe.
//
// Optional feature macro: KBD_OVERRUN_CODE_EN
//   defined   : a push into a full FIFO overwrites the newest entry with 8'hFF
//   undefined : a push into a full FIFO is dropped
//   In both builds a dropped or replaced byte sets the sticky overflow flag.
//
// Ports:
//   clock     in   system clock (clock_25 domain), rising edge
//   reset_n   in   asynchronous active-low reset
//   ps2_hit   in   byte-done flag (pulse or level); one push per rising edge
//   ps2_data  in   scancode, sampled in the push cycle
//   rd        in   pop strobe, one cycle per byte
//   clr       in   synchronous flush (empties FIFO, clears overflow)
//   data_o    out  byte at FIFO head (registered)
//   empty     out  FIFO holds no bytes
//   count     out  bytes stored, 0..2^DEPTH_LOG2
//   overflow  out  sticky: at least one byte dropped or replaced
//   irq       out  interrupt request, equals ~empty
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ps2_hit,
  input  logic [7:0]            ps2_data,
  input  logic                  rd,
  input  logic                  clr,
  output logic [7:0]            data_o,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_hit_q;
  logic [7:0]            r_data;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_ovr;
  logic [DEPTH_LOG2-1:0] w_head_inc;
  logic [DEPTH_LOG2-1:0] w_tail_inc;
  logic [DEPTH_LOG2:0]   w_count_nxt;

  always_comb begin
    w_push     = ps2_hit & ~r_hit_q;
    w_pop      = rd & ~r_empty;
    w_full     = (r_count == C_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_wr       = w_push & (~w_full | w_pop);
    w_ovr      = w_push & w_full & ~w_pop;
    w_head_inc = r_head + DEPTH_LOG2'(1);
    w_tail_inc = r_tail + DEPTH_LOG2'(1);
    w_count_nxt = r_count;
    if (w_wr && !w_pop)
      w_count_nxt = r_count + (DEPTH_LOG2+1)'(1);
    else if (!w_wr && w_pop)
      w_count_nxt = r_count - (DEPTH_LOG2+1)'(1);
  end

`ifdef KBD_OVERRUN_CODE_EN
  logic [DEPTH_LOG2-1:0] w_tail_dec;
  assign w_tail_dec = r_tail - DEPTH_LOG2'(1);
`endif

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (!clr) begin
      if (w_wr)
        r_mem[r_tail] <= ps2_data;
`ifdef KBD_OVERRUN_CODE_EN
      else if (w_ovr)
        r_mem[w_tail_dec] <= 8'hFF;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_q    <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      r_hit_q <= ps2_hit;
      if (clr) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_empty    <= 1'b1;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr)
          r_tail <= w_tail_inc;
        if (w_pop)
          r_head <= w_head_inc;
        if (w_ovr)
          r_overflow <= 1'b1;
        r_count <= w_count_nxt;
        r_empty <= (w_count_nxt == '0);
        // data_o tracks mem[head] of the next state; the incoming byte is
        // bypassed when it lands in the new head slot.
        if (w_pop) begin
          if (w_wr && (r_tail == w_head_inc))
            r_data <= ps2_data;
          else
            r_data <= r_mem[w_head_inc];
        end else if (w_wr && r_empty) begin
          r_data <= ps2_data;
        end
      end
    end
  end

  assign data_o   = r_data;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign irq      = ~r_empty;

endmodule

// File: tb/tb_kbd_fifo.sv
module tb_kbd_fifo;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_hit = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data_o;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  kbd_fifo #(.DEPTH_LOG2(4)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_hit(ps2_hit), .ps2_data(ps2_data),
    .rd(rd), .clr(clr), .data_o(data_o), .empty(empty), .count(count),
    .overflow(overflow), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard.
  always @(negedge clock) begin
    logic [7:0] e;
    if (reset_n) begin
      checks++;
      if (irq !== ~empty) begin
        errors++;
        $display("FAIL irq_vs_empty: irq %0b empty %0b at %0t", irq, empty, $time);
      end
      if (rd && !empty) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0h with no byte expected at %0t", data_o, $time);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e) begin
            errors++;
            $display("FAIL pop_data: got %0h expected %0h at %0t", data_o, e, $time);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int width);
    ps2_data = b;
    ps2_hit  = 1'b1;
    tick(width);
    ps2_hit  = 1'b0;
    tick(1);
  endtask

  task automatic do_rd();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic push_and_rd(input logic [7:0] b);
    ps2_data = b;
    ps2_hit  = 1'b1;
    rd       = 1'b1;
    tick(1);
    rd       = 1'b0;
    ps2_hit  = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_irq", irq, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", data_o, 8'h00);
    reset_n = 1'b1;
    tick(2);

    // Long ps2_hit level yields exactly one entry
    push_byte(8'h1C, 4); exp_q.push_back(8'h1C);
    check("lvl_count", count, 1);
    check("lvl_empty", empty, 0);
    check("lvl_irq", irq, 1);
    check("lvl_data", data_o, 8'h1C);
    do_rd();
    check("rd1_count", count, 0);
    check("rd1_empty", empty, 1);
    check("rd1_irq", irq, 0);

    // Push with coincident pop
    push_byte(8'hF0, 1); exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    push_and_rd(8'h1C);
    check("pp_count", count, 1);
    check("pp_data", data_o, 8'h1C);
    check("pp_overflow", overflow, 0);
    do_rd();

    // 17 pushes into 16 slots
    for (int i = 1; i <= 17; i++) push_byte(8'(i), 1);
`ifdef KBD_OVERRUN_CODE_EN
    for (int i = 1; i <= 15; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hFF);
`else
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
`endif
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) do_rd();
    check("ovf_drain_count", count, 0);
    check("ovf_sticky", overflow, 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_ovf", overflow, 0);

    // Full FIFO with coincident pop and push
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h20 + 8'(i), 1);
      exp_q.push_back(8'h20 + 8'(i));
    end
    check("full_count", count, 16);
    exp_q.push_back(8'h55);
    push_and_rd(8'h55);
    check("fullpp_count", count, 16);
    check("fullpp_overflow", overflow, 0);
    for (int i = 0; i < 16; i++) do_rd();
    check("fullpp_drain", count, 0);

    // clr beats a coincident push
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i), 1);
    check("fill5_count", count, 5);
    ps2_data = 8'h77; ps2_hit = 1'b1; clr = 1'b1;
    tick(1);
    clr = 1'b0; ps2_hit = 1'b0;
    exp_q.delete();
    tick(1);
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_overflow", overflow, 0);
    push_byte(8'h2A, 1); exp_q.push_back(8'h2A);
    check("after_clr_data", data_o, 8'h2A);
    do_rd();

    // rd while empty changes nothing
    do_rd();
    check("rd_empty_count", count, 0);
    check("rd_empty_empty", empty, 1);
    push_byte(8'h3C, 1); exp_q.push_back(8'h3C);
    check("rd_empty_next", count, 1);
    do_rd();

    // Asynchronous reset mid-fill
    for (int i = 0; i < 7; i++) push_byte(8'h40 + 8'(i), 1);
    check("fill7_count", count, 7);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_irq", irq, 0);
    check("arst_data", data_o, 8'h00);
    check("arst_overflow", overflow, 0);
    exp_q.delete();
    tick(1);
    reset_n = 1'b1;
    tick(2);
    check("post_rst_count", count, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
    $fatal(1);
  end

endmodule
